// File: rtl/modulo_scan_ctrl4.sv
// ============================================================================
// Module      : modulo_scan_ctrl4
// Description : Four-slot digit scan controller for a 4:1 display mux with
//               masked-digit skipping and optional inter-slot blanking.
//               Optional feature macro: SCAN_BLANK_EN (adds the BLANK state).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module modulo_scan_ctrl4 #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 500,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_mask,
    output logic [1:0] input_sel,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam logic [1:0] c_IDLE  = 2'd0;
`ifdef SCAN_BLANK_EN
    localparam logic [1:0] c_BLANK = 2'd1;
    localparam logic [CNT_W-1:0] c_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
`endif
    localparam logic [1:0] c_SHOW  = 2'd2;
    localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(DIV - 1);
    localparam int c_CNT_MAX = (DIV > BLANK_CYC) ? (DIV - 1) : (BLANK_CYC - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_sel;
    logic [3:0]       r_an;
    logic             r_fs;
    logic [CNT_W-1:0] r_timer;

    logic [1:0]       w_state_nx;
    logic [1:0]       w_sel_nx;
    logic [CNT_W-1:0] w_timer_nx;
    logic [CNT_W-1:0] w_tinc;
    logic [3:0]       w_an_nx;
    logic             w_fs_nx;
    logic             w_enter;
    logic [3:0]       w_slot_en;
    logic [1:0]       w_next;
    logic [1:0]       w_first;
    logic             w_run;
    logic             w_cur_en;

    // Slot k is fed from mux input 3-k, so the mask is bit-reversed per slot.
    function automatic logic [1:0] f_next(input logic [1:0] k, input logic [3:0] slot_en);
        logic [1:0] c;
        f_next = k;
        for (int i = 3; i >= 1; i--) begin
            c = k + 2'(i);
            if (slot_en[c]) f_next = c;
        end
    endfunction

    assign w_slot_en = {digit_mask[0], digit_mask[1], digit_mask[2], digit_mask[3]};
    assign w_next    = f_next(r_sel, w_slot_en);
    // Searching upward from slot 3 yields the lowest enabled slot.
    assign w_first   = f_next(2'd3, w_slot_en);
    assign w_run     = en && (digit_mask != 4'b0000);
    assign w_cur_en  = w_slot_en[r_sel];
    assign w_tinc    = (r_timer == CNT_W'(c_CNT_MAX)) ? r_timer : r_timer + 1'b1;

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_timer_nx = w_tinc;
        w_enter    = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_timer_nx = '0;
                if (w_run) begin
                    w_sel_nx = w_first;
`ifdef SCAN_BLANK_EN
                    w_state_nx = c_BLANK;
`else
                    w_state_nx = c_SHOW;
                    w_enter    = 1'b1;
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            c_BLANK: begin
                if (!w_run) begin
                    w_state_nx = c_IDLE;
                    w_timer_nx = '0;
                end else if (!w_cur_en) begin
                    w_sel_nx   = w_next;
                    w_timer_nx = '0;
                end else if (r_timer == c_BLANK_LAST) begin
                    w_state_nx = c_SHOW;
                    w_timer_nx = '0;
                    w_enter    = 1'b1;
                end
            end
`endif
            c_SHOW: begin
                if (!w_run) begin
                    w_state_nx = c_IDLE;
                    w_timer_nx = '0;
                end else if (!w_cur_en || (r_timer == c_DIV_LAST)) begin
                    w_sel_nx   = w_next;
                    w_timer_nx = '0;
`ifdef SCAN_BLANK_EN
                    w_state_nx = c_BLANK;
`else
                    w_enter    = 1'b1;
`endif
                end
            end
            default: begin
                w_state_nx = c_IDLE;
                w_timer_nx = '0;
            end
        endcase
        w_an_nx = (w_state_nx == c_SHOW) ? ~(4'b1000 >> w_sel_nx) : 4'b1111;
        w_fs_nx = w_enter && (w_sel_nx == w_first);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_sel   <= 2'b00;
            r_an    <= 4'b1111;
            r_fs    <= 1'b0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_an    <= w_an_nx;
            r_fs    <= w_fs_nx;
            r_timer <= w_timer_nx;
        end
    end

    assign input_sel   = r_sel;
    assign an          = r_an;
    assign frame_start = r_fs;

endmodule

`default_nettype wire
